minimac2_phy_tx: RTL

MINIMAC2_PHY_TX -- requirements
Module: minimac2_phy_tx

---
 rtl/minimac2_phy_tx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/minimac2_phy_tx.sv
// MII transmit engine: streams one frame from the packet buffer as
// preamble/SFD, payload nibbles and the Ethernet FCS, then holds the gap.
module minimac2_phy_tx #(
   parameter int unsigned IFG_CYCLES = 24
) (
   input  logic        phy_clk,
   input  logic        phy_rst_n,
   input  logic        tx_start,
   input  logic [10:0] tx_count,
   output logic        tx_busy,
   output logic        tx_done,
   output logic [10:0] phy_adr_o,
   input  logic [7:0]  phy_dat_i,
   output logic        phy_tx_en,
   output logic [3:0]  phy_tx_data
);

   localparam int unsigned CW = (IFG_CYCLES > 16) ? $clog2(IFG_CYCLES) : 4;
   localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 2);

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      DATA,
      CRC,
      IFG
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [10:0]   byte_q, byte_d;
   logic          nib_q, nib_d;
   logic [10:0]   count_q, count_d;
   logic [10:0]   adr_q, adr_d;
   logic [31:0]   crc_q, crc_d;
   logic [3:0]    hold_q, hold_d;
   logic          tx_en_q, tx_en_d;
   logic [3:0]    tx_data_q, tx_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          cap;
   logic [11:0]   cap_idx;
   logic [11:0]   cap_next;
   logic [31:0]   fcs_sh;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int unsigned i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      byte_d    = byte_q;
      nib_d     = nib_q;
      count_d   = count_q;
      adr_d     = adr_q;
      crc_d     = crc_q;
      hold_d    = hold_q;
      tx_en_d   = tx_en_q;
      tx_data_d = tx_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cap       = 1'b0;
      cap_idx   = '0;
      cap_next  = '0;
      fcs_sh    = (~crc_q) >> {cnt_q[2:0] + 3'd1, 2'b00};

      case (state_q)
         IDLE: begin
            if (tx_start) begin
               count_d = tx_count;
               byte_d  = '0;
               nib_d   = 1'b0;
               crc_d   = '1;
               adr_d   = '0;
               busy_d  = 1'b1;
               if (tx_count != 11'd0) begin
                  state_d   = PREAMBLE;
                  cnt_d     = '0;
                  tx_en_d   = 1'b1;
                  tx_data_d = 4'h5;
               end else begin
                  // Empty frame: jump to the final gap cycle so done follows next edge.
                  state_d = IFG;
                  cnt_d   = IFG_LAST;
               end
            end
         end
         PREAMBLE: begin
            if (cnt_q == CW'(15)) begin
               state_d = DATA;
               nib_d   = 1'b0;
               cap     = 1'b1;
               cap_idx = '0;
            end else begin
               cnt_d     = cnt_q + CW'(1);
               tx_data_d = (cnt_q == CW'(14)) ? 4'hD : 4'h5;
            end
         end
         DATA: begin
            if (!nib_q) begin
               nib_d     = 1'b1;
               tx_data_d = hold_q;
            end else if (({1'b0, byte_q} + 12'd1) == {1'b0, count_q}) begin
               state_d   = CRC;
               cnt_d     = '0;
               tx_data_d = ~crc_q[3:0];
            end else begin
               nib_d   = 1'b0;
               cap     = 1'b1;
               cap_idx = {1'b0, byte_q} + 12'd1;
            end
         end
         CRC: begin
            if (cnt_q == CW'(7)) begin
               state_d   = IFG;
               cnt_d     = '0;
               tx_en_d   = 1'b0;
               tx_data_d = 4'h0;
            end else begin
               cnt_d     = cnt_q + CW'(1);
               tx_data_d = fcs_sh[3:0];
            end
         end
         IFG: begin
            if (cnt_q == IFG_LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               adr_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Byte arrives one cycle after its address; the next address is issued
      // as each byte is captured, stopping at the last byte of the frame.
      if (cap) begin
         cap_next  = cap_idx + 12'd1;
         byte_d    = cap_idx[10:0];
         tx_data_d = phy_dat_i[3:0];
         hold_d    = phy_dat_i[7:4];
         crc_d     = crc_byte(crc_q, phy_dat_i);
         if (cap_next < {1'b0, count_q}) begin
            adr_d = cap_next[10:0];
         end
      end
   end

   always_ff @(posedge phy_clk) begin
      if (!phy_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         byte_q    <= '0;
         nib_q     <= 1'b0;
         count_q   <= '0;
         adr_q     <= '0;
         crc_q     <= '1;
         hold_q    <= '0;
         tx_en_q   <= 1'b0;
         tx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         byte_q    <= byte_d;
         nib_q     <= nib_d;
         count_q   <= count_d;
         adr_q     <= adr_d;
         crc_q     <= crc_d;
         hold_q    <= hold_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign tx_busy     = busy_q;
   assign tx_done     = done_q;
   assign phy_adr_o   = adr_q;
   assign phy_tx_en   = tx_en_q;
   assign phy_tx_data = tx_data_q;

endmodule
